// File: rtl/pa_rtu_trap_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pa_rtu_trap_arb : retire-side trap arbiter (dbg > nmi > lockup > int) with
//                   IFU flush handshake, CP0 commit pulse and flush watchdog.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pa_rtu_trap_arb #(
  parameter int TMO_W    = 8,
  parameter int INT_ID_W = 5
) (
  input  logic                trap_clk,
  input  logic                cpurst,
  input  logic                dbg_trap_req,
  input  logic                nmi_trap_req,
  input  logic                lockup_trap_req,
  input  logic                int_trap_req,
  input  logic [INT_ID_W-1:0] int_trap_id,
  input  logic                cp0_rtu_in_nmi,
  input  logic                retire_trap_dbgon,
  input  logic                retire_trap_ready,
  input  logic                ifu_rtu_trap_flush_ack,
  output logic                rtu_ifu_trap_flush_req,
  output logic                rtu_cp0_trap_vld,
  output logic [2:0]          rtu_cp0_trap_cause,
  output logic [INT_ID_W-1:0] rtu_cp0_trap_int_id,
  output logic [3:0]          trap_grant,
  output logic                rtu_sysio_trap_tmo,
  output logic                trap_arb_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FLSH = 2'b01,
    CMT  = 2'b10
  } state_t;

  localparam logic [2:0]       CAUSE_NONE = 3'd0;
  localparam logic [2:0]       CAUSE_DBG  = 3'd1;
  localparam logic [2:0]       CAUSE_NMI  = 3'd2;
  localparam logic [2:0]       CAUSE_LKP  = 3'd3;
  localparam logic [2:0]       CAUSE_INT  = 3'd4;
  localparam logic [TMO_W-1:0] CNT_MAX    = '1;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          cause_q;
  logic [INT_ID_W-1:0] int_id_q;
  logic [TMO_W-1:0]    cnt_q;
  logic                tmo_q;

  logic                dbg_eff;
  logic                nmi_eff;
  logic                lkp_eff;
  logic                int_eff;
  logic                any_req;
  logic                capture;
  logic [2:0]          sel_cause;

  // Debug is never masked; NMI handler masks nmi/int, debug mode masks all others.
  assign dbg_eff = dbg_trap_req;
  assign nmi_eff = nmi_trap_req    && !cp0_rtu_in_nmi && !retire_trap_dbgon;
  assign lkp_eff = lockup_trap_req && !retire_trap_dbgon;
  assign int_eff = int_trap_req    && !cp0_rtu_in_nmi && !retire_trap_dbgon;
  assign any_req = dbg_eff || nmi_eff || lkp_eff || int_eff;
  assign capture = (state == IDLE) && retire_trap_ready && any_req;

  always_comb begin
    sel_cause = CAUSE_NONE;
    if (dbg_eff)      sel_cause = CAUSE_DBG;
    else if (nmi_eff) sel_cause = CAUSE_NMI;
    else if (lkp_eff) sel_cause = CAUSE_LKP;
    else if (int_eff) sel_cause = CAUSE_INT;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (retire_trap_ready && any_req) state_nxt = FLSH;
      FLSH:    if (ifu_rtu_trap_flush_ack)       state_nxt = CMT;
      CMT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge trap_clk) begin
    if (cpurst) begin
      state    <= IDLE;
      cause_q  <= CAUSE_NONE;
      int_id_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cause_q  <= sel_cause;
        int_id_q <= (sel_cause == CAUSE_INT) ? int_trap_id : '0;
        cnt_q    <= '0;
      end
      // Watchdog saturates; the flag is sticky until reset.
      if (state == FLSH && !ifu_rtu_trap_flush_ack && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_MAX - 1'b1) tmo_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rtu_ifu_trap_flush_req = (state == FLSH);
    rtu_cp0_trap_vld       = (state == CMT);
    trap_arb_busy          = (state == FLSH) || (state == CMT);
    trap_grant             = 4'b0000;
    if (state == CMT) begin
      case (cause_q)
        CAUSE_DBG: trap_grant = 4'b0001;
        CAUSE_NMI: trap_grant = 4'b0010;
        CAUSE_LKP: trap_grant = 4'b0100;
        CAUSE_INT: trap_grant = 4'b1000;
        default:   trap_grant = 4'b0000;
      endcase
    end
  end

  assign rtu_cp0_trap_cause  = cause_q;
  assign rtu_cp0_trap_int_id = int_id_q;
  assign rtu_sysio_trap_tmo  = tmo_q;

endmodule
`default_nettype wire

// File: doc/pa_rtu_trap_arb.md
Name: pa_rtu_trap_arb

Overview:
- Retire-side trap arbiter; selects one trap source per trap window from four requesters: debug request, NMI, lockup exception and interrupt.
- Sequences the trap as: IFU flush handshake, then a one-cycle commit pulse to CP0 carrying the cause and interrupt ID.
- Enforces mask rules while the core is in an NMI handler or in debug mode.
- Runs a bounded flush-ack watchdog. Sits between the lockup state machine / interrupt controller and CP0/IFU.

Parameters:
TMO_W, 8, width of the flush-ack watchdog counter; timeout fires at count 2^TMO_W-1.
INT_ID_W, 5, width of the interrupt ID.

Ports:
- trap_clk  in  1  block clock.
- cpurst  in  1  synchronous, active-high reset.
- dbg_trap_req  in  1  debug entry request; level, held until granted.
- nmi_trap_req  in  1  NMI request; level.
- lockup_trap_req  in  1  lockup-exception request from the lockup FSM; level.
- int_trap_req  in  1  interrupt request; level.
- int_trap_id  in  INT_ID_W  interrupt ID, valid with int_trap_req.
- cp0_rtu_in_nmi  in  1  core is executing the NMI handler.
- retire_trap_dbgon  in  1  core is in debug mode.
- retire_trap_ready  in  1  retire stage can accept a trap this cycle.
- ifu_rtu_trap_flush_ack  in  1  IFU flush complete.
- rtu_ifu_trap_flush_req  out  1  flush request; level until ack.
- rtu_cp0_trap_vld  out  1  one-cycle trap commit pulse.
- rtu_cp0_trap_cause  out  3  0 none, 1 dbg, 2 nmi, 3 lockup, 4 int.
- rtu_cp0_trap_int_id  out  INT_ID_W  latched interrupt ID; 0 when cause is not 4.
- trap_grant  out  4  one-hot grant pulse {int,lockup,nmi,dbg}, same cycle as rtu_cp0_trap_vld.
- rtu_sysio_trap_tmo  out  1  sticky flush-ack timeout flag.
- trap_arb_busy  out  1  state not IDLE.

Behaviour:
- Reset: cpurst sampled at the trap_clk edge. State goes to IDLE; all outputs 0; cause/ID registers 0; counter 0; tmo flag 0. Reset mid-sequence abandons the trap with no grant and no commit.
- Effective requests:
  - dbg = dbg_trap_req (never masked).
  - nmi = nmi_trap_req && !cp0_rtu_in_nmi && !retire_trap_dbgon.
  - lkp = lockup_trap_req && !retire_trap_dbgon.
  - int = int_trap_req && !cp0_rtu_in_nmi && !retire_trap_dbgon.
- Fixed priority: dbg > nmi > lkp > int.
- States: IDLE (00), FLSH (01), CMT (10).
- IDLE:
  - If retire_trap_ready and any effective request: latch the winner's cause (and int_trap_id if the winner is int, else 0), clear the counter, go to FLSH.
  - Otherwise stay in IDLE.
- FLSH:
  - rtu_ifu_trap_flush_req = 1.
  - The selection is frozen. No preemption, even by debug. Requests that drop or mask during FLSH do not cancel the trap.
  - ifu_rtu_trap_flush_ack is sampled only in FLSH. Ack seen: go to CMT. Ack asserted in IDLE/CMT is ignored.
  - Without ack, the counter increments and saturates at 2^TMO_W-1. Reaching that value sets rtu_sysio_trap_tmo. The flag stays set until cpurst. The block keeps waiting in FLSH.
- CMT:
  - rtu_cp0_trap_vld = 1 and trap_grant bit = 1 for exactly one cycle.
  - rtu_cp0_trap_cause / rtu_cp0_trap_int_id present the latched values.
  - Next state is IDLE unconditionally. This guarantees at least one IDLE cycle between traps, so back-to-back traps are spaced 3 + flush-latency cycles apart.
- Minimum latency, request to commit pulse: 2 cycles (request sampled in IDLE; ack in the first FLSH cycle; CMT on the next edge).
- Cause/ID outputs hold their latched value from the FLSH entry until the next IDLE→FLSH capture. They are meaningful only while rtu_cp0_trap_vld = 1.
- trap_arb_busy = (state != IDLE).
- Undefined state encoding (11) returns to IDLE with outputs 0.

Test Plan:
- Single int: int_trap_req=1, id=5'd17, ready=1; ack returned 3 cycles after flush_req → flush_req high for 3 cycles, then trap_vld pulse with cause=4, int_id=17, grant=4'b1000; idle for 1 cycle afterwards.
- Priority: dbg, nmi and int asserted in the same cycle → cause=1, grant=4'b0001. Hold nmi and int → next trap is cause=2 with ≥1 idle cycle between; then cause=4.
- Masking: cp0_rtu_in_nmi=1 with nmi+int+lockup asserted → cause=3 only. With retire_trap_dbgon=1 and only nmi/int/lockup asserted → no flush_req.
- No preemption: int granted into FLSH, then dbg_trap_req rises before ack → commit cause=4; debug is committed in the following trap.
- Timeout: TMO_W=4, no ack → rtu_sysio_trap_tmo rises after 15 FLSH cycles and stays high. A late ack then gives a normal commit; tmo clears only on cpurst.
- Reset mid-op: assert cpurst while in FLSH → next edge state=IDLE, flush_req=0, no trap_vld, tmo=0.
